// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB round-robin arbiter master.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_ADDR_WIDTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PW      = $clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx,
    output logic               found
);

    logic          hi_found, lo_found;
    logic [PW-1:0] hi_idx, lo_idx;

    // Descending scan so the lowest index in each half wins; the upper half (>= ptr) has priority.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (PW'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = PW'(i);
                end
            end
        end
    end

    assign found = hi_found | lo_found;
    assign idx   = hi_found ? hi_idx : lo_idx;
    assign grant = found ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/apb_arbiter_master.sv
// APB master sharing one slave among NUM_REQ requesters with round-robin arbitration.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter_master
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
    input  logic                         pclk,
    input  logic                         presetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         psel,
    output logic                         pen,
    output logic                         pwrite,
    output logic [ADDR_WIDTH-1:0]        paddr,
    output logic [DATA_WIDTH-1:0]        pwdata,
    input  logic [DATA_WIDTH-1:0]        prdata,
    input  logic                         pready
);

    localparam int PW = $clog2(NUM_REQ);

    state_t                  state, next_state;
    logic [PW-1:0]           ptr, grant_idx, win_idx;
    logic [NUM_REQ-1:0]      win_onehot;
    logic                    win_found, done, timeout, accept;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (win_onehot),
        .idx   (win_idx),
        .found (win_found)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcnt;

    // Counter is held at zero outside ACCESS, so it starts fresh on every ACCESS entry.
    always_ff @(posedge pclk) begin
        if (!presetn || state != ACCESS)
            tcnt <= '0;
        else if (!pready)
            tcnt <= tcnt + CW'(1);
    end

    assign timeout = (state == ACCESS) && !pready && (tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // pready only counts in ACCESS; a lingering pready in IDLE/SETUP is ignored.
    assign done      = (state == ACCESS) && (pready || timeout);
    assign accept    = ((state == IDLE) || done) && win_found;
    assign req_ready = accept ? win_onehot : '0;

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (done) next_state = accept ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        psel = (state == SETUP) || (state == ACCESS);
        pen  = (state == ACCESS);
    end

    // Completion uses the old grant/direction while a new accept may overwrite them on the same edge.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            grant_idx <= '0;
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            if (accept) begin
                pwrite    <= sel_write;
                paddr     <= sel_addr;
                pwdata    <= sel_wdata;
                grant_idx <= win_idx;
                ptr       <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
            end
            if (done) begin
                rsp_valid <= NUM_REQ'(1) << grant_idx;
                rsp_err   <= timeout;
                rsp_rdata <= (pwrite || timeout) ? '0 : prdata;
            end
        end
    end

endmodule

// File: doc/apb_arbiter_master.md
Name: apb_arbiter_master

Overview:
- APB master that shares one APB slave (8-bit addr/data, registered pready) between NUM_REQ local requesters.
- Round-robin arbitration; drives the SETUP/ACCESS protocol and returns read data to the granted requester.
- Sits between the core-side requesters and the apb_slave memory.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 8, pwdata/prdata width.
- ADDR_WIDTH, 8, paddr width.
- TIMEOUT_CYCLES, 16, ACCESS-phase limit (used only with the optional feature).

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- presetn  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*AW +: AW].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_ready  out  NUM_REQ  one-hot acceptance (combinational).
- rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse (registered).
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid (0 for writes).
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- psel  out  1  APB select.
- pen  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.

Behaviour:
- Reset (presetn=0 at an edge):
  - psel, pen, pwrite = 0; paddr, pwdata = 0.
  - rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - state = IDLE; round-robin pointer = 0.
  - A transfer in flight is dropped and gets no response.
- States:
  - IDLE: psel=0, pen=0.
  - SETUP: psel=1, pen=0; lasts exactly 1 cycle.
  - ACCESS: psel=1, pen=1.
- Arbitration:
  - Arbitration is evaluated in IDLE, and in ACCESS on the completing cycle (pready=1).
  - The winner is the first asserted req_valid at or after the pointer, scanning upward with wrap.
  - req_ready[winner]=1 in that cycle; all other bits are 0. req_ready is 0 in SETUP and in non-completing ACCESS.
  - Requesters must hold valid/write/addr/wdata stable until ready.
- Accept edge:
  - Latch write, addr, wdata and the grant index.
  - Pointer <= winner+1, modulo NUM_REQ.
  - Go to SETUP.
- SETUP -> ACCESS unconditionally.
- ACCESS exit:
  - pready is sampled only in ACCESS. A stale pready=1 in IDLE/SETUP is ignored. The slave holds pready high for one cycle after pen falls.
  - On pready=1: capture prdata into rsp_rdata (reads only; 0 for writes). Pulse rsp_valid[grant] the next cycle with rsp_err=0.
  - Next state is SETUP if a new winner exists (back-to-back, no IDLE cycle); otherwise IDLE.
- Latency with the apb_slave:
  - Accept edge E.
  - SETUP in cycle E+1.
  - ACCESS in E+2 and E+3 (pready is seen in E+3).
  - rsp_valid in E+4.
- Simultaneous events: a completion and a new grant in the same cycle are legal. The rsp_valid of the old transfer and the SETUP of the new one coincide.
- Widths: no arithmetic on the data path. The pointer is $clog2(NUM_REQ) bits and wraps explicitly at NUM_REQ-1.

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
- Defined:
  - An ACCESS counter clears on ACCESS entry and increments each cycle pready=0.
  - When it reaches TIMEOUT_CYCLES, the transfer is force-completed: rsp_valid[grant]=1, rsp_err=1, rsp_rdata=0.
  - Arbitration and next state then follow the normal completion rules.
- Not defined: no counter is present, ACCESS waits indefinitely, and rsp_err is tied 0.

Decomposition:
- Package apb_arb_pkg:
  - state enum {IDLE, SETUP, ACCESS}, 2 bits.
  - Default width constants.
- One sub-module: apb_rr_arbiter (combinational round-robin pick; inputs req vector and pointer; outputs one-hot grant and index).

Test Plan:
- Single requester, req0 write addr 0x10 data 0xA5, then read 0x10 -> psel at E+1, pen at E+2..E+3, rsp_valid[0] at E+4; read returns rsp_rdata=0xA5.
- req0 and req1 held valid continuously, 4 writes each -> grants alternate 0,1,0,1; no IDLE cycles between transfers; no requester waits more than 1 transfer.
- Back-to-back: req1 read 0x20 arrives during req0 ACCESS -> req1 SETUP in the same cycle as req0 rsp_valid; no stale-pready early completion.
- presetn=0 during ACCESS -> next cycle psel=pen=0 and rsp_valid=0; pointer back to 0; the aborted requester gets no response.
- With APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready tied 0 -> rsp_valid with rsp_err=1 and rsp_rdata=0 after 4 ACCESS cycles; the next request proceeds normally.
- Stale pready: force pready=1 during SETUP -> no completion; the transfer completes only after an ACCESS-phase pready.
